// File: rtl/four_bit_rca.sv
// rtl/four_bit_rca.sv - 4-bit ripple-carry adder with combinational and registered sum, carry and overflow
// Four chained full-adder stages; the registered copies are the only stateful part.

module rca_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p;

    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module four_bit_rca (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       V,
    output logic [3:0] S_q,
    output logic       Cout_q,
    output logic       V_q
);
    // Separate carry nets per stage keep the ripple chain explicit.
    logic c1, c2, c3, c4;
    logic s0, s1, s2, s3;

    rca_full_adder u_fa0 (.a_i(A[0]), .b_i(B[0]), .c_i(Cin), .s_o(s0), .c_o(c1));
    rca_full_adder u_fa1 (.a_i(A[1]), .b_i(B[1]), .c_i(c1),  .s_o(s1), .c_o(c2));
    rca_full_adder u_fa2 (.a_i(A[2]), .b_i(B[2]), .c_i(c2),  .s_o(s2), .c_o(c3));
    rca_full_adder u_fa3 (.a_i(A[3]), .b_i(B[3]), .c_i(c3),  .s_o(s3), .c_o(c4));

    logic [3:0] s_d;
    logic       cout_d;
    logic       v_d;

    assign s_d    = {s3, s2, s1, s0};
    assign cout_d = c4;
    assign v_d    = c3 ^ c4;

    assign S    = s_d;
    assign Cout = cout_d;
    assign V    = v_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q    <= 4'd0;
            Cout_q <= 1'b0;
            V_q    <= 1'b0;
        end else begin
            S_q    <= s_d;
            Cout_q <= cout_d;
            V_q    <= v_d;
        end
    end
endmodule

// File: tb/tb_four_bit_rca.sv
// tb/tb_four_bit_rca.sv - self-checking bench for four_bit_rca
// Reference model uses plain integer arithmetic on unsigned and signed interpretations.

module tb_four_bit_rca;
    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout;
    logic       V;
    logic [3:0] S_q;
    logic       Cout_q;
    logic       V_q;

    int n_checks = 0;
    int n_fail   = 0;

    four_bit_rca dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .S      (S),
        .Cout   (Cout),
        .V      (V),
        .S_q    (S_q),
        .Cout_q (Cout_q),
        .V_q    (V_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {V, Cout, S[3:0]} from unsigned and two's-complement sums.
    function automatic logic [5:0] ref_add(input int a, input int b, input int cin);
        int usum;
        int ssum;
        int sa;
        int sb;
        logic ovf;
        usum = a + b + cin;
        sa   = (a >= 8) ? a - 16 : a;
        sb   = (b >= 8) ? b - 16 : b;
        ssum = sa + sb + cin;
        ovf  = (ssum > 7) || (ssum < -8);
        return {ovf, usum[4], usum[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        logic [5:0] e;
        e = ref_add(int'(A), int'(B), int'(Cin));
        check(tag, 32'({V, Cout, S}), 32'(e));
    endtask

    task automatic drive(input int a, input int b, input int cin);
        A   = 4'(a);
        B   = 4'(b);
        Cin = 1'(cin);
    endtask

    logic [5:0] exp_r;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0);
        #3;
        check("reset_regs", 32'({V_q, Cout_q, S_q}), 32'd0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    drive(a, b, c);
                    #10;
                    check_comb("exhaustive");
                    #10;
                end
        check("regs_held_in_reset", 32'({V_q, Cout_q, S_q}), 32'd0);

        drive(15, 0, 1);  #2; check("bnd_15_0_1", 32'({V, Cout, S}), 32'({1'b0, 1'b1, 4'd0}));
        drive(15, 15, 1); #2; check("bnd_15_15_1", 32'({Cout, S}), 32'({1'b1, 4'd15}));
        drive(0, 0, 0);   #2; check("bnd_0_0_0", 32'({Cout, S}), 32'd0);
        drive(7, 1, 0);   #2; check("ovf_7_1", 32'({V, Cout, S}), 32'({1'b1, 1'b0, 4'd8}));
        drive(8, 8, 0);   #2; check("ovf_8_8", 32'({V, Cout, S}), 32'({1'b1, 1'b1, 4'd0}));
        drive(15, 1, 0);  #2; check("ovf_15_1", 32'({V, Cout, S}), 32'({1'b0, 1'b1, 4'd0}));

        drive(15, 0, 0);  #2; check("ripple_before", 32'({Cout, S}), 32'({1'b0, 4'd15}));
        drive(15, 0, 1);  #2; check("ripple_after", 32'({Cout, S}), 32'({1'b1, 4'd0}));

        @(negedge clk);
        rst_n = 1'b1;
        drive(9, 8, 1);
        #1;
        check("pre_edge_regs", 32'({V_q, Cout_q, S_q}), 32'd0);
        @(posedge clk); #1;
        check("first_capture", 32'({V_q, Cout_q, S_q}), 32'({1'b1, 1'b1, 4'd2}));

        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_regs", 32'({V_q, Cout_q, S_q}), 32'd0);
        check("async_reset_comb", 32'(S), 32'd2);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            drive(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));
            exp_r = ref_add(int'(A), int'(B), int'(Cin));
            #1;
            check_comb("rand_comb");
            @(posedge clk); #1;
            check("rand_reg", 32'({V_q, Cout_q, S_q}), 32'(exp_r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
